// File: rtl/alu_share_arbiter.sv
// Round-robin time-share of one external ALU between two requesters.
// The winner's operands are latched at grant, held for EXEC_CYCLES, then the result returns with a done pulse.
module alu_share_arbiter #(
    parameter int DATA_W      = 32,
    parameter int EXEC_CYCLES = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req0,
    input  logic              req1,
    input  logic [3:0]        aluop0,
    input  logic [3:0]        aluop1,
    input  logic [DATA_W-1:0] porta0,
    input  logic [DATA_W-1:0] porta1,
    input  logic [DATA_W-1:0] portb0,
    input  logic [DATA_W-1:0] portb1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] out0,
    output logic [DATA_W-1:0] out1,
    output logic [2:0]        flags0,
    output logic [2:0]        flags1,
    output logic              busy,
    output logic [3:0]        alu_aluop,
    output logic [DATA_W-1:0] alu_porta,
    output logic [DATA_W-1:0] alu_portb,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    input  logic              alu_negative,
    input  logic              alu_overflow
);

    localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               rr_q, rr_d;
    logic               gnt_q, gnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         aluop_q, aluop_d;
    logic [DATA_W-1:0]  porta_q, porta_d;
    logic [DATA_W-1:0]  portb_q, portb_d;
    logic               capture;
    logic               win;

    logic [DATA_W-1:0]  out_q   [2];
    logic [DATA_W-1:0]  out_d   [2];
    logic [2:0]         flags_q [2];
    logic [2:0]         flags_d [2];
    logic               done_vec [2];

    // Contention goes to the rr pointer; otherwise whoever is asking.
    assign win = (req0 && req1) ? rr_q : req1;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        aluop_d = aluop_q;
        porta_d = porta_q;
        portb_d = portb_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    gnt_d   = win;
                    aluop_d = win ? aluop1 : aluop0;
                    porta_d = win ? porta1 : porta0;
                    portb_d = win ? portb1 : portb0;
                    cnt_d   = CNT_LOAD;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                rr_d    = ~gnt_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            gnt_q   <= 1'b0;
            cnt_q   <= '0;
            aluop_q <= 4'b0000;
            porta_q <= '0;
            portb_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            aluop_q <= aluop_d;
            porta_q <= porta_d;
            portb_q <= portb_d;
        end
    end

    // Per-requester result registers: only the granted side ever updates.
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        always_comb begin
            out_d[gi]   = out_q[gi];
            flags_d[gi] = flags_q[gi];
            if (capture && (gnt_q == 1'(gi))) begin
                out_d[gi]   = alu_out;
                flags_d[gi] = {alu_overflow, alu_negative, alu_zero};
            end
        end

        always_ff @(posedge CLK) begin
            if (RST) begin
                out_q[gi]   <= '0;
                flags_q[gi] <= 3'b000;
            end else begin
                out_q[gi]   <= out_d[gi];
                flags_q[gi] <= flags_d[gi];
            end
        end

        assign done_vec[gi] = (state_q == RESP) && (gnt_q == 1'(gi));
    end

    assign done0     = done_vec[0];
    assign done1     = done_vec[1];
    assign out0      = out_q[0];
    assign out1      = out_q[1];
    assign flags0    = flags_q[0];
    assign flags1    = flags_q[1];
    assign busy      = (state_q != IDLE);
    assign alu_aluop = aluop_q;
    assign alu_porta = porta_q;
    assign alu_portb = portb_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Two arbiters (EXEC_CYCLES=1 and 3) share one stimulus stream; a timeline model predicts every output each cycle.
module tb_alu_share_arbiter;

    localparam int DW = 32;
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLT = 4'd5;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic           RST, req0, req1;
    logic [3:0]     aluop0, aluop1;
    logic [DW-1:0]  porta0, porta1, portb0, portb1;

    logic           done0_w [2];
    logic           done1_w [2];
    logic           busy_w  [2];
    logic [DW-1:0]  out0_w  [2];
    logic [DW-1:0]  out1_w  [2];
    logic [2:0]     fl0_w   [2];
    logic [2:0]     fl1_w   [2];
    logic [3:0]     aop_w   [2];
    logic [DW-1:0]  apa_w   [2];
    logic [DW-1:0]  apb_w   [2];
    logic [34:0]    alu_bus [2];

    int total = 0;
    int bad   = 0;

    // Reference ALU: returns {overflow, negative, zero, result}
    function automatic logic [34:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        ov;
        r  = 32'd0;
        ov = 1'b0;
        case (op)
            4'd0: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
            4'd1: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = a;
        endcase
        return {ov, r[31], (r == 32'd0), r};
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        assign alu_bus[gi] = alu_fn(aop_w[gi], apa_w[gi], apb_w[gi]);
        alu_share_arbiter #(.DATA_W(DW), .EXEC_CYCLES(gi == 0 ? 1 : 3)) u_dut (
            .CLK(CLK), .RST(RST),
            .req0(req0), .req1(req1),
            .aluop0(aluop0), .aluop1(aluop1),
            .porta0(porta0), .porta1(porta1),
            .portb0(portb0), .portb1(portb1),
            .done0(done0_w[gi]), .done1(done1_w[gi]),
            .out0(out0_w[gi]), .out1(out1_w[gi]),
            .flags0(fl0_w[gi]), .flags1(fl1_w[gi]),
            .busy(busy_w[gi]),
            .alu_aluop(aop_w[gi]), .alu_porta(apa_w[gi]), .alu_portb(apb_w[gi]),
            .alu_out(alu_bus[gi][31:0]),
            .alu_zero(alu_bus[gi][32]), .alu_negative(alu_bus[gi][33]), .alu_overflow(alu_bus[gi][34])
        );
    end

    // Model: each instance is a timeline of grant -> done -> free cycles
    int          cyc;
    int          free_at [2];
    int          done_at [2];
    int          gnt     [2];
    int          rr      [2];
    logic [31:0] m_out   [2][2];
    logic [2:0]  m_flg   [2][2];
    logic [31:0] pend_res [2];
    logic [2:0]  pend_flg [2];
    logic [3:0]  m_op    [2];
    logic [31:0] m_a     [2];
    logic [31:0] m_b     [2];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic int ec_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic model_reset(input int i, input int next_cyc);
        free_at[i] = next_cyc;
        done_at[i] = -1;
        gnt[i] = 0;
        rr[i]  = 0;
        m_op[i] = 4'd0;
        m_a[i]  = 32'd0;
        m_b[i]  = 32'd0;
        for (int k = 0; k < 2; k++) begin
            m_out[i][k] = 32'd0;
            m_flg[i][k] = 3'b000;
        end
    endtask

    // One clock cycle: check this cycle's outputs, apply inputs, advance model, step clock.
    task automatic step(input logic r,
                        input logic q0, input logic [3:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                        input logic q1, input logic [3:0] o1, input logic [31:0] a1, input logic [31:0] b1);
        int w;
        for (int i = 0; i < 2; i++) begin
            if (cyc == done_at[i]) begin
                m_out[i][gnt[i]] = pend_res[i];
                m_flg[i][gnt[i]] = pend_flg[i];
                $display("inst%0d cyc=%0d done req%0d result=%h flags=%b", i, cyc, gnt[i], pend_res[i], pend_flg[i]);
            end
            check_val($sformatf("i%0d_done0", i), 64'(done0_w[i]), 64'((cyc == done_at[i]) && (gnt[i] == 0)));
            check_val($sformatf("i%0d_done1", i), 64'(done1_w[i]), 64'((cyc == done_at[i]) && (gnt[i] == 1)));
            check_val($sformatf("i%0d_busy", i),  64'(busy_w[i]),  64'(cyc < free_at[i]));
            check_val($sformatf("i%0d_out0", i),  64'(out0_w[i]),  64'(m_out[i][0]));
            check_val($sformatf("i%0d_out1", i),  64'(out1_w[i]),  64'(m_out[i][1]));
            check_val($sformatf("i%0d_flags0", i), 64'(fl0_w[i]),  64'(m_flg[i][0]));
            check_val($sformatf("i%0d_flags1", i), 64'(fl1_w[i]),  64'(m_flg[i][1]));
            check_val($sformatf("i%0d_alu_op", i), 64'(aop_w[i]),  64'(m_op[i]));
            check_val($sformatf("i%0d_alu_a", i),  64'(apa_w[i]),  64'(m_a[i]));
            check_val($sformatf("i%0d_alu_b", i),  64'(apb_w[i]),  64'(m_b[i]));
        end
        RST = r; req0 = q0; aluop0 = o0; porta0 = a0; portb0 = b0;
        req1 = q1; aluop1 = o1; porta1 = a1; portb1 = b1;
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                model_reset(i, cyc + 1);
            end else if (cyc >= free_at[i] && (q0 || q1)) begin
                w = (q0 && q1) ? rr[i] : (q1 ? 1 : 0);
                gnt[i]  = w;
                m_op[i] = w ? o1 : o0;
                m_a[i]  = w ? a1 : a0;
                m_b[i]  = w ? b1 : b0;
                {pend_flg[i], pend_res[i]} = alu_fn(m_op[i], m_a[i], m_b[i]);
                done_at[i] = cyc + 1 + ec_of(i);
                free_at[i] = cyc + 2 + ec_of(i);
                rr[i] = 1 - w;
            end
        end
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
    endtask

    initial begin
        RST = 1'b1; req0 = 1'b0; req1 = 1'b0;
        aluop0 = 4'd0; aluop1 = 4'd0;
        porta0 = '0; porta1 = '0; portb0 = '0; portb1 = '0;
        @(posedge CLK);
        #1;
        cyc = 0;
        model_reset(0, 0);
        model_reset(1, 0);
        step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);

        // Single request ADD 5+7
        for (int k = 0; k < 2; k++) step(1'b0, 1'b1, OP_ADD, 32'd5, 32'd7, 1'b0, 4'd0, 32'd0, 32'd0);
        idle(6);
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("i%0d_add_out0", i), 64'(out0_w[i]), 64'd12);
            check_val($sformatf("i%0d_add_out1", i), 64'(out1_w[i]), 64'd0);
        end

        // Simultaneous SUB 3-3 vs ADD 1+1
        for (int k = 0; k < 6; k++) step(1'b0, 1'b1, OP_SUB, 32'd3, 32'd3, 1'b1, OP_ADD, 32'd1, 32'd1);
        idle(10);
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("i%0d_sub_out0", i), 64'(out0_w[i]), 64'd0);
            check_val($sformatf("i%0d_sub_flags0", i), 64'(fl0_w[i]), 64'(3'b001));
            check_val($sformatf("i%0d_add_out1b", i), 64'(out1_w[i]), 64'd2);
        end

        // Signed overflow on requester 1
        step(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, OP_ADD, 32'h7FFF_FFFF, 32'h1);
        idle(8);
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("i%0d_ovf_out1", i), 64'(out1_w[i]), 64'h8000_0000);
            check_val($sformatf("i%0d_ovf_flags1", i), 64'(fl1_w[i]), 64'(3'b110));
            check_val($sformatf("i%0d_ovf_flags0", i), 64'(fl0_w[i]), 64'(3'b001));
        end

        // SLT -1 < 1, operand changes after grant must be ignored
        step(1'b0, 1'b1, OP_SLT, 32'hFFFF_FFFF, 32'd1, 1'b0, 4'd0, 32'd0, 32'd0);
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0, OP_SLT, 32'd5, 32'd1, 1'b0, 4'd0, 32'd0, 32'd0);
        for (int i = 0; i < 2; i++) check_val($sformatf("i%0d_slt_out0", i), 64'(out0_w[i]), 64'd1);

        // Reset while in EXEC abandons the op
        step(1'b0, 1'b1, OP_ADD, 32'd9, 32'd9, 1'b0, 4'd0, 32'd0, 32'd0);
        step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
        for (int i = 0; i < 2; i++) check_val($sformatf("i%0d_rst_busy", i), 64'(busy_w[i]), 64'd0);
        idle(5);
        step(1'b0, 1'b1, OP_ADD, 32'd2, 32'd2, 1'b0, 4'd0, 32'd0, 32'd0);
        idle(6);
        for (int i = 0; i < 2; i++) check_val($sformatf("i%0d_post_rst_out0", i), 64'(out0_w[i]), 64'd4);

        // Continuous contention: grants must alternate
        for (int k = 0; k < 40; k++)
            step(1'b0, 1'b1, OP_ADD, 32'(k), 32'd100, 1'b1, OP_SUB, 32'(k), 32'd100);
        idle(8);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 2000; n++) begin
            step($urandom_range(0, 99) < 2,
                 $urandom_range(0, 2) != 0, 4'($urandom_range(0, 6)), $urandom, $urandom,
                 $urandom_range(0, 2) != 0, 4'($urandom_range(0, 6)), $urandom, $urandom);
        end
        idle(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
